execute_stage_reg: RTL and testbench

// - Parametrised Decode->Execute pipeline register for the pipelined Y86-64 core.
// - Sits between the decode stage and the execute stage.
// - Adds the following on top of plain per-cycle capture:
//   - synchronous reset, stall (hold) and bubble (NOP inject) with fixed priority;
//   - a configurable register-ID encoding for bubble fields;
//   - an occupancy flag;
//   - saturating performance counters;
//   - a sticky control-conflict flag.

---
 rtl/y86_pkg.sv | 32 +++
 rtl/sat_counter.sv | 23 ++
 rtl/execute_stage_reg.sv | 105 ++++++++++
 tb/tb_execute_stage_reg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, instruction codes, the "no register"
// ID and the default datapath widths used by the pipeline registers.
package y86_pkg;

  localparam int WORD_W = 64;
  localparam int REG_W  = 4;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [3:0] {
    ICODE_HALT   = 4'h0,
    ICODE_NOP    = 4'h1,
    ICODE_RRMOVQ = 4'h2,
    ICODE_IRMOVQ = 4'h3,
    ICODE_RMMOVQ = 4'h4,
    ICODE_MRMOVQ = 4'h5,
    ICODE_OPQ    = 4'h6,
    ICODE_JXX    = 4'h7,
    ICODE_CALL   = 4'h8,
    ICODE_RET    = 4'h9,
    ICODE_PUSHQ  = 4'hA,
    ICODE_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; rst and clr both
// zero it, and a clear beats an increment in the same cycle.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/execute_stage_reg.sv
// Decode->Execute pipeline register with stall/bubble control, occupancy flag,
// saturating bubble/stall counters and a sticky stall+bubble conflict flag.
module execute_stage_reg #(
  parameter int               WORD_W     = y86_pkg::WORD_W,
  parameter int               REG_W      = y86_pkg::REG_W,
  parameter logic [REG_W-1:0] BUBBLE_REG = y86_pkg::RNONE,
  parameter logic [2:0]       STAT_AOK   = y86_pkg::STAT_AOK,
  parameter logic [3:0]       ICODE_NOP  = y86_pkg::ICODE_NOP,
  parameter int               CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic              clr_stats,
  input  logic [2:0]        d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [WORD_W-1:0] d_valC,
  input  logic [WORD_W-1:0] d_valA,
  input  logic [WORD_W-1:0] d_valB,
  input  logic [REG_W-1:0]  d_dstE,
  input  logic [REG_W-1:0]  d_dstM,
  input  logic [REG_W-1:0]  d_srcA,
  input  logic [REG_W-1:0]  d_srcB,
  output logic [2:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [WORD_W-1:0] E_valC,
  output logic [WORD_W-1:0] E_valA,
  output logic [WORD_W-1:0] E_valB,
  output logic [REG_W-1:0]  E_dstE,
  output logic [REG_W-1:0]  E_dstM,
  output logic [REG_W-1:0]  E_srcA,
  output logic [REG_W-1:0]  E_srcB,
  output logic              E_valid,
  output logic [CNT_W-1:0]  cnt_bubble,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic              conflict
);

  logic stall_only;
  logic ctl_conflict;

  assign stall_only   = E_stall && !E_bubble;
  assign ctl_conflict = E_stall && E_bubble;

  // Reset and bubble load the same NOP image; a plain stall simply skips the
  // update.
  // NOTE: leaving fields unassigned in a clocked block holds the flop value;
  // the same omission in combinational logic would infer a latch.
  always_ff @(posedge clk) begin
    if (rst || E_bubble) begin
      E_stat  <= STAT_AOK;
      E_icode <= ICODE_NOP;
      E_ifun  <= '0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= BUBBLE_REG;
      E_dstM  <= BUBBLE_REG;
      E_srcA  <= BUBBLE_REG;
      E_srcB  <= BUBBLE_REG;
      E_valid <= 1'b0;
    end else if (!E_stall) begin
      E_stat  <= d_stat;
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valC  <= d_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
      E_valid <= (d_icode != ICODE_NOP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      conflict <= 1'b0;
    end else if (ctl_conflict) begin
      conflict <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_bubble (
    .clk   (clk),
    .rst   (rst),
    .inc   (E_bubble),
    .clr   (clr_stats),
    .count (cnt_bubble)
  );

  // A stall overridden by a bubble is not a stall cycle.
  sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_only),
    .clr   (clr_stats),
    .count (cnt_stall)
  );

endmodule

// File: tb/tb_execute_stage_reg.sv
// Directed bench for execute_stage_reg: a behavioural model pushes the expected
// post-edge state into a queue as each cycle is driven; it is popped and compared after the edge.
module tb_execute_stage_reg;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } fields_t;

  typedef struct packed {
    fields_t          f;
    logic             valid;
    logic [CNT_W-1:0] cb;
    logic [CNT_W-1:0] cs;
    logic             conf;
  } exp_t;

  localparam fields_t NOP_F = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0,
                                valC: 64'h0, valA: 64'h0, valB: 64'h0,
                                dstE: 4'hF, dstM: 4'hF, srcA: 4'hF, srcB: 4'hF};

  logic clk = 1'b0;
  logic rst = 1'b0, E_stall = 1'b0, E_bubble = 1'b0, clr_stats = 1'b0;
  logic [2:0]  d_stat = '0;
  logic [3:0]  d_icode = '0, d_ifun = '0;
  logic [63:0] d_valC = '0, d_valA = '0, d_valB = '0;
  logic [3:0]  d_dstE = '0, d_dstM = '0, d_srcA = '0, d_srcB = '0;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
  logic        E_valid, conflict;
  logic [CNT_W-1:0] cnt_bubble, cnt_stall;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t    q[$];
  fields_t m_f;
  logic    m_valid;
  logic [CNT_W-1:0] m_cb, m_cs;
  logic    m_conf;

  always #5 clk = ~clk;

  execute_stage_reg #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .E_stall    (E_stall),
    .E_bubble   (E_bubble),
    .clr_stats  (clr_stats),
    .d_stat     (d_stat),
    .d_icode    (d_icode),
    .d_ifun     (d_ifun),
    .d_valC     (d_valC),
    .d_valA     (d_valA),
    .d_valB     (d_valB),
    .d_dstE     (d_dstE),
    .d_dstM     (d_dstM),
    .d_srcA     (d_srcA),
    .d_srcB     (d_srcB),
    .E_stat     (E_stat),
    .E_icode    (E_icode),
    .E_ifun     (E_ifun),
    .E_valC     (E_valC),
    .E_valA     (E_valA),
    .E_valB     (E_valB),
    .E_dstE     (E_dstE),
    .E_dstM     (E_dstM),
    .E_srcA     (E_srcA),
    .E_srcB     (E_srcB),
    .E_valid    (E_valid),
    .cnt_bubble (cnt_bubble),
    .cnt_stall  (cnt_stall),
    .conflict   (conflict)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic fields_t rand_din();
    fields_t d;
    d.stat  = 3'($urandom_range(1, 4));
    d.icode = 4'($urandom_range(0, 11));
    d.ifun  = 4'($urandom);
    d.valC  = {$urandom, $urandom};
    d.valA  = {$urandom, $urandom};
    d.valB  = {$urandom, $urandom};
    d.dstE  = 4'($urandom);
    d.dstM  = 4'($urandom);
    d.srcA  = 4'($urandom);
    d.srcB  = 4'($urandom);
    return d;
  endfunction

  // Behavioural reference: reset > bubble > stall > load; clr zeroes stats.
  task automatic model(input logic r, input logic s, input logic b, input logic c,
                       input fields_t din);
    if (r) begin
      m_f = NOP_F; m_valid = 1'b0; m_cb = '0; m_cs = '0; m_conf = 1'b0;
    end else begin
      if (b) begin
        m_f = NOP_F; m_valid = 1'b0;
      end else if (!s) begin
        m_f = din; m_valid = (din.icode != 4'h1);
      end
      if (c) begin
        m_cb = '0; m_cs = '0; m_conf = 1'b0;
      end else begin
        if (b && m_cb != {CNT_W{1'b1}}) m_cb = m_cb + 1'b1;
        if (s && !b && m_cs != {CNT_W{1'b1}}) m_cs = m_cs + 1'b1;
        if (s && b) m_conf = 1'b1;
      end
    end
    q.push_back('{f: m_f, valid: m_valid, cb: m_cb, cs: m_cs, conf: m_conf});
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic c,
                      input fields_t din);
    exp_t e;
    rst = r; E_stall = s; E_bubble = b; clr_stats = c;
    d_stat = din.stat; d_icode = din.icode; d_ifun = din.ifun;
    d_valC = din.valC; d_valA = din.valA; d_valB = din.valB;
    d_dstE = din.dstE; d_dstM = din.dstM; d_srcA = din.srcA; d_srcB = din.srcB;
    model(r, s, b, c, din);
    @(posedge clk);
    #1;
    check("queue_nonempty", 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check("E_stat",     64'(E_stat),     64'(e.f.stat));
      check("E_icode",    64'(E_icode),    64'(e.f.icode));
      check("E_ifun",     64'(E_ifun),     64'(e.f.ifun));
      check("E_valC",     E_valC,          e.f.valC);
      check("E_valA",     E_valA,          e.f.valA);
      check("E_valB",     E_valB,          e.f.valB);
      check("E_dstE",     64'(E_dstE),     64'(e.f.dstE));
      check("E_dstM",     64'(E_dstM),     64'(e.f.dstM));
      check("E_srcA",     64'(E_srcA),     64'(e.f.srcA));
      check("E_srcB",     64'(E_srcB),     64'(e.f.srcB));
      check("E_valid",    64'(E_valid),    64'(e.valid));
      check("cnt_bubble", 64'(cnt_bubble), 64'(e.cb));
      check("cnt_stall",  64'(cnt_stall),  64'(e.cs));
      check("conflict",   64'(conflict),   64'(e.conf));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fields_t d;

    // Reset for two cycles with random decode inputs.
    step(1, 0, 0, 0, rand_din());
    step(1, 0, 0, 0, rand_din());
    check("rst_icode", 64'(E_icode), 64'h1);
    check("rst_stat",  64'(E_stat),  64'h1);
    check("rst_dstE",  64'(E_dstE),  64'hF);
    check("rst_srcA",  64'(E_srcA),  64'hF);
    check("rst_valA",  E_valA,       64'h0);
    check("rst_valid", 64'(E_valid), 64'h0);

    // Plain load.
    d = rand_din();
    d.icode = 4'h6; d.valA = 64'hDEAD_BEEF; d.dstE = 4'h3;
    step(0, 0, 0, 0, d);
    check("load_valA",  E_valA,          64'hDEAD_BEEF);
    check("load_dstE",  64'(E_dstE),     64'h3);
    check("load_valid", 64'(E_valid),    64'h1);

    // Load icode 2, then stall three cycles with fresh inputs.
    d = rand_din();
    d.icode = 4'h2;
    step(0, 0, 0, 0, d);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, rand_din());
    check("stall_icode", 64'(E_icode),   64'h2);
    check("stall_cnt",   64'(cnt_stall), 64'd3);

    // Stall and bubble together: bubble wins, conflict latches.
    step(0, 1, 1, 0, rand_din());
    check("conf_icode", 64'(E_icode),    64'h1);
    check("conf_flag",  64'(conflict),   64'h1);
    check("conf_cb",    64'(cnt_bubble), 64'd1);
    check("conf_cs",    64'(cnt_stall),  64'd3);

    // A few loads including an explicit NOP (not a real instruction).
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, rand_din());
    d = rand_din();
    d.icode = 4'h1;
    step(0, 0, 0, 0, d);
    check("nop_valid", 64'(E_valid), 64'h0);

    // Clear stats while loading; then saturate the bubble counter.
    step(0, 0, 0, 1, rand_din());
    check("clr_conf", 64'(conflict), 64'h0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, rand_din());
    check("sat_cb", 64'(cnt_bubble), 64'd15);
    step(0, 0, 1, 1, rand_din());
    check("clr_cb", 64'(cnt_bubble), 64'd0);
    step(0, 1, 1, 0, rand_din());
    step(0, 0, 0, 1, rand_din());
    check("clr_conf2", 64'(conflict), 64'h0);

    // Reset in the middle of a stall, then release and load.
    step(0, 0, 0, 0, rand_din());
    step(0, 1, 0, 0, rand_din());
    step(1, 1, 0, 0, rand_din());
    check("rst_stall_icode", 64'(E_icode), 64'h1);
    d = rand_din();
    d.icode = 4'h5;
    step(0, 0, 0, 0, d);
    check("rel_valA",  E_valA,          d.valA);
    check("rel_valid", 64'(E_valid),    64'h1);

    // Mixed random control traffic.
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), rand_din());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
